// File: rtl/cpu_pipe_pkg.sv
// cpu_pipe_pkg: shared pipeline constants and payload types for the CPU pipe registers
package cpu_pipe_pkg;
  localparam int PIPE_XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0033;
  typedef struct packed {
    logic [PIPE_XLEN-1:0] instrn;
    logic [PIPE_XLEN-1:0] pc_addrout;
    logic [PIPE_XLEN-1:0] pcp4;
  } if_id_payload_t;
endpackage

// File: rtl/pipe_skid_slot.sv
// pipe_skid_slot: one payload register with a valid flag; clear wins over load
module pipe_skid_slot #(
  parameter int W = 96
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid <= 1'b0;
      q     <= '0;
    end else begin
      valid <= clear ? 1'b0 : (load ? 1'b1 : valid);
      if (load && !clear) q <= d;
    end
endmodule

// File: rtl/if_id_pipe_reg.sv
// if_id_pipe_reg: IF->ID pipeline register with valid/ready handshake, optional skid slot and flush
module if_id_pipe_reg
  import cpu_pipe_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(cpu_pipe_pkg::NOP_INSTR),
  parameter bit              SKID_EN   = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [XLEN-1:0] if_instrn,
  input  logic [XLEN-1:0] if_pc_addrout,
  input  logic [XLEN-1:0] if_pcp4,
  input  logic            flush,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_instrn,
  output logic [XLEN-1:0] id_pc_addrout,
  output logic [XLEN-1:0] id_pcp4,
  output logic [1:0]      occupancy
);
  localparam int W = 3 * XLEN;
  logic [W-1:0] in_p, main_d, main_q, skid_q;
  logic main_v, skid_v, rdy_en, push, pop, main_free, main_ld, main_clr;
  // holds if_ready low while in reset so fetch sees ready only from the first edge after release
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdy_en <= 1'b0;
    else        rdy_en <= 1'b1;
  assign in_p      = {if_instrn, if_pc_addrout, if_pcp4};
  assign push      = if_valid & if_ready;
  assign pop       = main_v & id_ready;
  assign main_free = ~main_v | pop;
  assign main_ld   = ~flush & main_free & (skid_v | push);
  assign main_clr  = flush | (pop & ~skid_v & ~push);
  assign main_d    = skid_v ? skid_q : in_p;
  pipe_skid_slot #(.W(W)) u_main (
    .clk(clk), .rst_n(rst_n), .load(main_ld), .clear(main_clr),
    .d(main_d), .valid(main_v), .q(main_q)
  );
  generate
    if (SKID_EN) begin : g_skid
      logic skid_ld, skid_clr;
      assign skid_ld  = ~flush & push & ~main_free;
      assign skid_clr = flush | (skid_v & main_free);
      pipe_skid_slot #(.W(W)) u_skid (
        .clk(clk), .rst_n(rst_n), .load(skid_ld), .clear(skid_clr),
        .d(in_p), .valid(skid_v), .q(skid_q)
      );
      assign if_ready = rdy_en & ~skid_v;
    end else begin : g_noskid
      assign skid_v   = 1'b0;
      assign skid_q   = '0;
      assign if_ready = rdy_en & main_free;
    end
  endgenerate
  assign id_valid      = main_v;
  assign id_instrn     = main_v ? main_q[W-1 -: XLEN] : NOP_INSTR;
  assign id_pc_addrout = main_q[2*XLEN-1 -: XLEN];
  assign id_pcp4       = main_q[XLEN-1:0];
  assign occupancy     = {1'b0, main_v} + {1'b0, skid_v};
endmodule

// File: tb/tb_if_id_pipe_reg.sv
// tb_if_id_pipe_reg: directed self-checking bench for skid (XLEN=32) and no-skid (XLEN=64) builds
module tb_if_id_pipe_reg;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  int tests = 0, fails = 0;
  logic        a_if_valid = 0, a_id_ready = 0, a_flush = 0;
  logic        a_if_ready, a_id_valid;
  logic [31:0] a_if_instrn = 0, a_if_pc = 0, a_if_pcp4 = 0;
  logic [31:0] a_id_instrn, a_id_pc, a_id_pcp4;
  logic [1:0]  a_occ;
  logic        b_if_valid = 0, b_id_ready = 0, b_flush = 0;
  logic        b_if_ready, b_id_valid;
  logic [63:0] b_if_instrn = 0, b_if_pc = 0, b_if_pcp4 = 0;
  logic [63:0] b_id_instrn, b_id_pc, b_id_pcp4;
  logic [1:0]  b_occ;

  if_id_pipe_reg #(.XLEN(32), .SKID_EN(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .if_valid(a_if_valid), .if_ready(a_if_ready),
    .if_instrn(a_if_instrn), .if_pc_addrout(a_if_pc), .if_pcp4(a_if_pcp4),
    .flush(a_flush), .id_valid(a_id_valid), .id_ready(a_id_ready),
    .id_instrn(a_id_instrn), .id_pc_addrout(a_id_pc), .id_pcp4(a_id_pcp4),
    .occupancy(a_occ)
  );
  if_id_pipe_reg #(.XLEN(64), .SKID_EN(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .if_valid(b_if_valid), .if_ready(b_if_ready),
    .if_instrn(b_if_instrn), .if_pc_addrout(b_if_pc), .if_pcp4(b_if_pcp4),
    .flush(b_flush), .id_valid(b_id_valid), .id_ready(b_id_ready),
    .id_instrn(b_id_instrn), .id_pc_addrout(b_id_pc), .id_pcp4(b_id_pcp4),
    .occupancy(b_occ)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [31:0] ins, input logic [31:0] pc);
    a_if_valid = v; a_if_instrn = ins; a_if_pc = pc; a_if_pcp4 = pc + 32'd4;
  endtask

  task automatic chk_a(input string name, input logic v, input logic [31:0] ins,
                       input logic [1:0] occ, input logic rdy);
    tests++;
    if (a_id_valid !== v || a_id_instrn !== ins || a_occ !== occ || a_if_ready !== rdy) begin
      fails++;
      $display("FAIL %s got valid=%0b instr=%h occ=%0d rdy=%0b want valid=%0b instr=%h occ=%0d rdy=%0b",
               name, a_id_valid, a_id_instrn, a_occ, a_if_ready, v, ins, occ, rdy);
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    step();
    chk_a("reset", 1'b0, 32'h33, 2'd0, 1'b1);
    tests++;
    if (a_id_pc !== 32'h0 || a_id_pcp4 !== 32'h0) begin
      fails++; $display("FAIL reset_pc got %h/%h want 0/0", a_id_pc, a_id_pcp4);
    end
    tests++;
    if (b_id_valid !== 1'b0 || b_id_instrn !== 64'h33 || b_occ !== 2'd0 || b_if_ready !== 1'b1) begin
      fails++; $display("FAIL reset_b got valid=%0b instr=%h occ=%0d rdy=%0b want 0 33 0 1",
                        b_id_valid, b_id_instrn, b_occ, b_if_ready);
    end
  endtask

  task automatic test_stream();
    a_id_ready = 1;
    drive_a(1, 32'h00500093, 32'h100);
    step();
    chk_a("stream_a", 1'b1, 32'h00500093, 2'd1, 1'b1);
    tests++;
    if (a_id_pc !== 32'h100 || a_id_pcp4 !== 32'h104) begin
      fails++; $display("FAIL stream_a_pc got %h/%h want 100/104", a_id_pc, a_id_pcp4);
    end
    drive_a(1, 32'h00A00113, 32'h104);
    step();
    chk_a("stream_b", 1'b1, 32'h00A00113, 2'd1, 1'b1);
    tests++;
    if (a_id_pc !== 32'h104 || a_id_pcp4 !== 32'h108) begin
      fails++; $display("FAIL stream_b_pc got %h/%h want 104/108", a_id_pc, a_id_pcp4);
    end
    drive_a(0, 32'h0, 32'h0);
    step();
    chk_a("stream_drain", 1'b0, 32'h33, 2'd0, 1'b1);
    tests++;
    if (a_id_pc !== 32'h104) begin
      fails++; $display("FAIL empty_pc_hold got %h want 104", a_id_pc);
    end
  endtask

  task automatic test_stall();
    a_id_ready = 0;
    drive_a(1, 32'hA0A0_0001, 32'h200);
    step();
    chk_a("stall_a", 1'b1, 32'hA0A0_0001, 2'd1, 1'b1);
    drive_a(1, 32'hB0B0_0002, 32'h204);
    step();
    chk_a("stall_b_skid", 1'b1, 32'hA0A0_0001, 2'd2, 1'b0);
    drive_a(1, 32'hC0C0_0003, 32'h208);
    step();
    chk_a("stall_hold", 1'b1, 32'hA0A0_0001, 2'd2, 1'b0);
    a_id_ready = 1;
    step();
    chk_a("drain_b", 1'b1, 32'hB0B0_0002, 2'd1, 1'b1);
    tests++;
    if (a_id_pc !== 32'h204 || a_id_pcp4 !== 32'h208) begin
      fails++; $display("FAIL drain_b_pc got %h/%h want 204/208", a_id_pc, a_id_pcp4);
    end
    step();
    chk_a("drain_c", 1'b1, 32'hC0C0_0003, 2'd1, 1'b1);
    drive_a(0, 32'h0, 32'h0);
    step();
    chk_a("drain_empty", 1'b0, 32'h33, 2'd0, 1'b1);
  endtask

  task automatic test_flush();
    a_id_ready = 0;
    drive_a(1, 32'hD0D0_0004, 32'h300);
    step();
    drive_a(1, 32'hE0E0_0005, 32'h304);
    step();
    chk_a("flush_pre", 1'b1, 32'hD0D0_0004, 2'd2, 1'b0);
    drive_a(1, 32'hF0F0_0006, 32'h308);
    a_flush = 1;
    step();
    a_flush = 0;
    chk_a("flush_two", 1'b0, 32'h33, 2'd0, 1'b1);
    drive_a(1, 32'h1111_0007, 32'h400);
    step();
    chk_a("flush_one_pre", 1'b1, 32'h1111_0007, 2'd1, 1'b1);
    drive_a(1, 32'h2222_0008, 32'h404);
    a_flush = 1;
    step();
    a_flush = 0;
    chk_a("flush_kills_push", 1'b0, 32'h33, 2'd0, 1'b1);
    drive_a(1, 32'h3333_0009, 32'h500);
    a_id_ready = 1;
    step();
    chk_a("post_flush_push", 1'b1, 32'h3333_0009, 2'd1, 1'b1);
    drive_a(0, 32'h0, 32'h0);
    step();
  endtask

  task automatic test_async_reset();
    a_id_ready = 0;
    drive_a(1, 32'h4444_000A, 32'h600);
    step();
    drive_a(1, 32'h5555_000B, 32'h604);
    step();
    chk_a("arst_pre", 1'b1, 32'h4444_000A, 2'd2, 1'b0);
    drive_a(0, 32'h0, 32'h0);
    #2 rst_n = 0;
    #1;
    chk_a("arst_async", 1'b0, 32'h33, 2'd0, 1'b0);
    tests++;
    if (a_id_pc !== 32'h0 || a_id_pcp4 !== 32'h0) begin
      fails++; $display("FAIL arst_pc got %h/%h want 0/0", a_id_pc, a_id_pcp4);
    end
    @(posedge clk);
    #1 rst_n = 1;
    step();
    chk_a("arst_release", 1'b0, 32'h33, 2'd0, 1'b1);
  endtask

  task automatic test_noskid();
    b_id_ready = 0;
    b_if_valid = 1; b_if_instrn = 64'hAAAA_0000_0000_0001; b_if_pc = 64'h1000; b_if_pcp4 = 64'h1004;
    step();
    tests++;
    if (b_id_valid !== 1'b1 || b_id_instrn !== 64'hAAAA_0000_0000_0001 || b_occ !== 2'd1 || b_if_ready !== 1'b0) begin
      fails++; $display("FAIL ns_a got valid=%0b instr=%h occ=%0d rdy=%0b want 1 aaaa000000000001 1 0",
                        b_id_valid, b_id_instrn, b_occ, b_if_ready);
    end
    b_if_instrn = 64'hBBBB_0000_0000_0002; b_if_pc = 64'h1004; b_if_pcp4 = 64'h1008;
    step();
    tests++;
    if (b_id_instrn !== 64'hAAAA_0000_0000_0001 || b_occ !== 2'd1 || b_if_ready !== 1'b0) begin
      fails++; $display("FAIL ns_hold got instr=%h occ=%0d rdy=%0b want aaaa000000000001 1 0",
                        b_id_instrn, b_occ, b_if_ready);
    end
    b_id_ready = 1;
    #1;
    tests++;
    if (b_if_ready !== 1'b1) begin
      fails++; $display("FAIL ns_comb_ready got %0b want 1", b_if_ready);
    end
    step();
    tests++;
    if (b_id_valid !== 1'b1 || b_id_instrn !== 64'hBBBB_0000_0000_0002 || b_id_pcp4 !== 64'h1008 || b_occ !== 2'd1) begin
      fails++; $display("FAIL ns_b got valid=%0b instr=%h pcp4=%h occ=%0d want 1 bbbb000000000002 1008 1",
                        b_id_valid, b_id_instrn, b_id_pcp4, b_occ);
    end
    b_if_instrn = 64'hCCCC_0000_0000_0003; b_if_pc = 64'h1008; b_if_pcp4 = 64'h100C;
    step();
    tests++;
    if (b_id_instrn !== 64'hCCCC_0000_0000_0003 || b_occ !== 2'd1) begin
      fails++; $display("FAIL ns_c got instr=%h occ=%0d want cccc000000000003 1", b_id_instrn, b_occ);
    end
    b_if_valid = 0;
    step();
    tests++;
    if (b_id_valid !== 1'b0 || b_id_instrn !== 64'h33 || b_occ !== 2'd0) begin
      fails++; $display("FAIL ns_empty got valid=%0b instr=%h occ=%0d want 0 33 0", b_id_valid, b_id_instrn, b_occ);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_async_reset();
    test_noskid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
